// File: rtl/instr_fetch.sv
// Instruction fetch/issue: one outstanding imem read feeding a {pc, instr} prefetch FIFO.
// Latency: rvalid in cycle N puts the word at the head (ivalid=1) in cycle N+1.
// Backpressure: a fetch is requested only while buffered + in-flight words < DEPTH.

module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push_vld,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop_rdy,
    output logic [W-1:0]                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_rdy)  rd_ptr <= rd_ptr + 1'b1;
            if (push_vld && !pop_rdy)      count <= count + 1'b1;
            else if (!push_vld && pop_rdy) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module instr_fetch #(
    parameter int            n        = 16,
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [n-1:0]  imem_rdata,
    output logic          ivalid,
    input  logic          iready,
    output logic [n-1:0]  instr,
    output logic [4:0]    op,
    output logic [AW-1:0] pc,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc
);
    localparam int            CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DROP} fetch_state_t;

    fetch_state_t     state_q, state_d;
    logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]    req_pc_q;
    logic [CW-1:0]    count;
    logic [AW+n-1:0]  head;
    logic             grant;
    logic             push;
    logic             pop;

    // Requests only issue from REQ, where nothing is in flight, so count alone is the space check.
    assign imem_req  = rst_n && (state_q == ST_REQ) && (count < DEPTH_C);
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt && !redirect;
    assign push      = (state_q == ST_WAIT) && imem_rvalid && !redirect;
    assign ivalid    = (count != '0);
    assign pop       = ivalid && iready && !redirect;
    assign instr     = ivalid ? head[n-1:0] : '0;
    assign pc        = ivalid ? head[AW+n-1:n] : '0;
    assign op        = instr[n-1:n-5];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            // A response still owed must be swallowed before the new stream starts.
            case (state_q)
                ST_WAIT: state_d = imem_rvalid ? ST_REQ : ST_DROP;
                ST_DROP: state_d = imem_rvalid ? ST_REQ : ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem_req && imem_gnt) begin
                        state_d    = ST_WAIT;
                        fetch_pc_d = fetch_pc_q + 1'b1;
                    end
                end
                ST_WAIT: if (imem_rvalid) state_d = ST_REQ;
                ST_DROP: if (imem_rvalid) state_d = ST_REQ;
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (grant) req_pc_q <= fetch_pc_q;
        end
    end

    fifo #(
        .W     (AW + n),
        .DEPTH (DEPTH)
    ) u_prefetch (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .push_vld (push),
        .push_dat ({req_pc_q, imem_rdata}),
        .pop_rdy  (pop),
        .head_dat (head),
        .count    (count)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a behavioural memory, directed scenarios and a randomized stream check.
`timescale 1ns/1ps
module tb_instr_fetch;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        iready = 0, redirect = 0;
    logic [15:0] redirect_pc = '0;

    logic        d0_req, d0_ivalid, d1_req, d1_ivalid;
    logic [15:0] d0_addr, d0_instr, d0_pc, d1_addr, d1_instr, d1_pc;
    logic [4:0]  d0_op, d1_op;
    logic        d0_gnt = 0, d0_rvalid = 0, d1_gnt = 0, d1_rvalid = 0;
    logic [15:0] m_rdata = '0;

    int n_tests = 0, n_fail = 0;

    bit          sel1 = 0, mem_en = 0, mem_rand = 0;
    int          mem_lat = 1;
    bit          pend = 0;
    logic [15:0] pend_addr;
    int          pend_cnt;
    logic        m_gnt = 0, m_rvalid = 0;
    logic [31:0] pop_q[$];
    logic [15:0] grant_q[$];

    wire        m_req    = sel1 ? d1_req : d0_req;
    wire [15:0] m_addr   = sel1 ? d1_addr : d0_addr;
    wire        m_ivalid = sel1 ? d1_ivalid : d0_ivalid;
    wire [15:0] m_pc     = sel1 ? d1_pc : d0_pc;
    wire [15:0] m_instr  = sel1 ? d1_instr : d0_instr;

    instr_fetch #(.n(16), .AW(16), .RESET_PC(16'h0000), .DEPTH(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .imem_req(d0_req), .imem_addr(d0_addr), .imem_gnt(d0_gnt),
        .imem_rvalid(d0_rvalid), .imem_rdata(m_rdata), .ivalid(d0_ivalid), .iready(iready),
        .instr(d0_instr), .op(d0_op), .pc(d0_pc), .redirect(redirect), .redirect_pc(redirect_pc));

    instr_fetch #(.n(16), .AW(16), .RESET_PC(16'hFFFF), .DEPTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .imem_req(d1_req), .imem_addr(d1_addr), .imem_gnt(d1_gnt),
        .imem_rvalid(d1_rvalid), .imem_rdata(m_rdata), .ivalid(d1_ivalid), .iready(iready),
        .instr(d1_instr), .op(d1_op), .pc(d1_pc), .redirect(redirect), .redirect_pc(redirect_pc));

    always #5 clk = ~clk;

    function automatic logic [15:0] memword(input logic [15:0] a);
        case (a)
            16'd0:   return 16'h9800;
            16'd1:   return 16'h9C00;
            16'd2:   return 16'h7000;
            default: return (a * 16'h9E37) ^ 16'h5A5A;
        endcase
    endfunction

    // Memory: drives just after the rising edge, books the cycle's outcome after the falling edge.
    initial forever begin
        @(posedge clk); #1;
        if (!rst_n || !mem_en) begin
            pend = 0; m_gnt = 0; m_rvalid = 0;
        end else begin
            m_rvalid = pend && pend_cnt == 1;
            m_rdata  = m_rvalid ? memword(pend_addr) : 16'($urandom);
            m_gnt    = m_req && !pend && (!mem_rand || $urandom_range(0, 1) == 1);
        end
        d0_gnt = m_gnt && !sel1; d0_rvalid = m_rvalid && !sel1;
        d1_gnt = m_gnt && sel1;  d1_rvalid = m_rvalid && sel1;
        @(negedge clk); #2;
        if (!rst_n) pend = 0;
        else if (m_rvalid) pend = 0;
        else if (pend) pend_cnt--;
        else if (m_gnt && m_req && !redirect) begin
            pend = 1; pend_addr = m_addr;
            pend_cnt = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
        end
    end

    initial forever begin
        @(negedge clk); #1;
        if (rst_n) begin
            if (m_ivalid && iready && !redirect) pop_q.push_back({m_pc, m_instr});
            if (m_req && m_gnt && !redirect) grant_q.push_back(m_addr);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset(input bit use1, input int lat, input bit rnd);
        rst_n = 0; redirect = 0; redirect_pc = '0; iready = 0;
        sel1 = use1; mem_lat = lat; mem_rand = rnd; mem_en = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        pop_q.delete(); grant_q.delete();
        rst_n = 1;
    endtask

    task automatic wait_pops(input int k, input string name);
        int c = 0;
        while (pop_q.size() < k && c < 60) begin @(negedge clk); c++; end
        #2;
        if (pop_q.size() < k) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got %0d pops required %0d", name, pop_q.size(), k);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_tests++; if (d0_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b required 0", d0_req); end
        n_tests++; if (d0_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h required 0000", d0_addr); end
        n_tests++; if (d1_addr !== 16'hFFFF) begin n_fail++; $display("FAIL reset_addr1: got %h required ffff", d1_addr); end
        n_tests++; if ({d0_ivalid, d0_instr, d0_op, d0_pc} !== 38'd0) begin n_fail++;
            $display("FAIL reset_head: got v=%b i=%h op=%b pc=%h required zeros", d0_ivalid, d0_instr, d0_op, d0_pc); end
        rst_n = 1; #1;
        n_tests++; if (d0_req !== 1'b1 || d0_addr !== 16'h0000) begin n_fail++;
            $display("FAIL reset_first_req: got req=%b addr=%h required 1/0000", d0_req, d0_addr); end
    endtask

    task automatic test_linear();
        int c = 0;
        logic [15:0] exp_instr[3] = '{16'h9800, 16'h9C00, 16'h7000};
        logic [4:0]  exp_op[3]    = '{5'b10011, 5'b10011, 5'b01110};
        do_reset(0, 1, 0);
        iready = 1;
        while (!d0_rvalid && c < 20) begin @(negedge clk); c++; end
        @(negedge clk);
        n_tests++; if (d0_ivalid !== 1'b1 || d0_pc !== 16'h0 || d0_instr !== 16'h9800 || d0_req !== 1'b1) begin n_fail++;
            $display("FAIL linear_latency: got v=%b pc=%h instr=%h req=%b required 1/0000/9800/1", d0_ivalid, d0_pc, d0_instr, d0_req); end
        wait_pops(3, "linear");
        for (int i = 0; i < 3 && i < pop_q.size(); i++) begin
            logic [31:0] e;
            logic [4:0]  got_op;
            e = pop_q[i];
            got_op = e[15:11];
            n_tests++; if (e[31:16] !== 16'(i) || e[15:0] !== exp_instr[i] || got_op !== exp_op[i]) begin n_fail++;
                $display("FAIL linear_pop%0d: got pc=%h instr=%h op=%b required pc=%h instr=%h op=%b",
                         i, e[31:16], e[15:0], got_op, 16'(i), exp_instr[i], exp_op[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(0, 1, 0);
        repeat (20) @(negedge clk);
        n_tests++; if (grant_q.size() !== 2 || d0_req !== 1'b0 || d0_ivalid !== 1'b1 || d0_pc !== 16'h0) begin n_fail++;
            $display("FAIL bp_full: got grants=%0d req=%b v=%b pc=%h required 2/0/1/0000", grant_q.size(), d0_req, d0_ivalid, d0_pc); end
        @(posedge clk); #1 iready = 1;
        @(posedge clk); #1 iready = 0;
        repeat (20) @(negedge clk);
        #2;
        n_tests++; if (pop_q.size() !== 1 || (pop_q.size() > 0 && pop_q[0][31:16] !== 16'h0)) begin n_fail++;
            $display("FAIL bp_pop: got pops=%0d required 1 with pc 0000", pop_q.size()); end
        n_tests++; if (grant_q.size() !== 3 || (grant_q.size() > 2 && grant_q[2] !== 16'h2) || d0_req !== 1'b0 || d0_pc !== 16'h1) begin n_fail++;
            $display("FAIL bp_refill: got grants=%0d req=%b head pc=%h required 3 grants (last 0002)/0/0001", grant_q.size(), d0_req, d0_pc); end
    endtask

    task automatic test_redirect_wait();
        int c = 0;
        bit bad = 0;
        do_reset(0, 2, 0);
        iready = 1;
        while (!(d0_req && d0_gnt && d0_addr == 16'h3) && c < 60) begin @(negedge clk); c++; end
        @(posedge clk); #1 redirect = 1; redirect_pc = 16'h0040;
        @(posedge clk); #1 redirect = 0;
        @(negedge clk);
        n_tests++; if (d0_ivalid !== 1'b0 || d0_req !== 1'b0) begin n_fail++;
            $display("FAIL redir_drop: got v=%b req=%b required 0/0", d0_ivalid, d0_req); end
        @(negedge clk);
        n_tests++; if (d0_req !== 1'b1 || d0_addr !== 16'h0040) begin n_fail++;
            $display("FAIL redir_newreq: got req=%b addr=%h required 1/0040", d0_req, d0_addr); end
        repeat (15) @(negedge clk);
        #2;
        foreach (pop_q[i]) if (pop_q[i][31:16] == 16'h3) bad = 1;
        n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL redir_pc3: got pc 0003 issued required none"); end
        n_tests++; if (grant_q.size() < 5 || grant_q[3] !== 16'h3 || grant_q[4] !== 16'h0040) begin n_fail++;
            $display("FAIL redir_grants: got %0d grants required ..0003,0040", grant_q.size()); end
    endtask

    task automatic test_redirect_pop_rvalid();
        int c = 0;
        do_reset(0, 1, 0);
        while (!(d0_ivalid && d0_req && d0_gnt) && c < 30) begin @(negedge clk); c++; end
        @(posedge clk); #1 iready = 1; redirect = 1; redirect_pc = 16'h0100;
        @(negedge clk);
        n_tests++; if ({d0_ivalid, d0_rvalid} !== 2'b11) begin n_fail++;
            $display("FAIL rpr_setup: got v=%b rvalid=%b required 1/1", d0_ivalid, d0_rvalid); end
        pop_q.delete();
        @(posedge clk); #1 redirect = 0;
        @(negedge clk);
        n_tests++; if ({d0_ivalid, d0_op, d0_instr, d0_pc} !== 38'd0) begin n_fail++;
            $display("FAIL rpr_empty: got v=%b op=%b instr=%h pc=%h required zeros", d0_ivalid, d0_op, d0_instr, d0_pc); end
        n_tests++; if (d0_req !== 1'b1 || d0_addr !== 16'h0100) begin n_fail++;
            $display("FAIL rpr_req: got req=%b addr=%h required 1/0100", d0_req, d0_addr); end
        wait_pops(1, "rpr");
        n_tests++; if (pop_q.size() == 0 || pop_q[0] !== {16'h0100, memword(16'h0100)}) begin n_fail++;
            $display("FAIL rpr_next: got %h required %h", pop_q.size() ? pop_q[0] : 32'h0, {16'h0100, memword(16'h0100)}); end
    endtask

    task automatic test_wrap();
        do_reset(1, 1, 0);
        iready = 1;
        wait_pops(2, "wrap");
        n_tests++; if (grant_q.size() < 2 || grant_q[0] !== 16'hFFFF || grant_q[1] !== 16'h0000) begin n_fail++;
            $display("FAIL wrap_fetch: got %0d grants required ffff,0000", grant_q.size()); end
        n_tests++; if (pop_q.size() < 2 || pop_q[0] !== {16'hFFFF, memword(16'hFFFF)} || pop_q[1] !== {16'h0000, 16'h9800}) begin n_fail++;
            $display("FAIL wrap_pc: got %h,%h required %h,%h", pop_q.size() > 0 ? pop_q[0] : 32'h0, pop_q.size() > 1 ? pop_q[1] : 32'h0,
                     {16'hFFFF, memword(16'hFFFF)}, {16'h0000, 16'h9800}); end
        sel1 = 0;
    endtask

    task automatic test_async_reset();
        int c = 0;
        do_reset(0, 3, 0);
        while (!(d0_ivalid && d0_req && d0_gnt) && c < 30) begin @(negedge clk); c++; end
        @(posedge clk); #3 rst_n = 0; #1;
        n_tests++; if (d0_ivalid !== 1'b0 || d0_req !== 1'b0 || d0_pc !== 16'h0) begin n_fail++;
            $display("FAIL areset_now: got v=%b req=%b pc=%h required 0/0/0000", d0_ivalid, d0_req, d0_pc); end
        repeat (2) @(posedge clk);
        @(negedge clk); pop_q.delete(); grant_q.delete(); rst_n = 1; #1;
        n_tests++; if (d0_req !== 1'b1 || d0_addr !== 16'h0000) begin n_fail++;
            $display("FAIL areset_restart: got req=%b addr=%h required 1/0000", d0_req, d0_addr); end
        iready = 1;
        wait_pops(1, "areset");
        n_tests++; if (pop_q.size() == 0 || pop_q[0] !== {16'h0000, 16'h9800}) begin n_fail++;
            $display("FAIL areset_first: got %h required 00009800", pop_q.size() ? pop_q[0] : 32'h0); end
    endtask

    // Stream model: between redirects the decoder sees pc = start, start+1, ... with memword(pc).
    task automatic test_random();
        logic [15:0] exp_pc = 16'h0, exp_fetch = 16'h0, rpc_prev = 16'h0, w;
        bit redir_prev = 0;
        int pops = 0;
        do_reset(0, 1, 1);
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(posedge clk); #1;
            iready      = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            @(negedge clk);
            if (redir_prev) begin
                n_tests++; if (d0_ivalid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush: cyc %0d ivalid=%b required 0", cyc, d0_ivalid); end
                if (!pend) begin
                    n_tests++; if (d0_req !== 1'b1 || d0_addr !== rpc_prev) begin n_fail++;
                        $display("FAIL rnd_redir_req: cyc %0d got req=%b addr=%h required 1/%h", cyc, d0_req, d0_addr, rpc_prev); end
                end
            end
            if (pend) begin
                n_tests++; if (d0_req !== 1'b0) begin n_fail++; $display("FAIL rnd_outstanding: cyc %0d req=%b required 0", cyc, d0_req); end
            end
            if (!d0_ivalid) begin
                n_tests++; if ({d0_instr, d0_op, d0_pc} !== 37'd0) begin n_fail++;
                    $display("FAIL rnd_empty_head: cyc %0d instr=%h op=%b pc=%h required zeros", cyc, d0_instr, d0_op, d0_pc); end
            end else if (iready && !redirect) begin
                w = memword(exp_pc);
                n_tests++; if (d0_pc !== exp_pc || d0_instr !== w || d0_op !== w[15:11]) begin n_fail++;
                    $display("FAIL rnd_pop: cyc %0d got pc=%h instr=%h op=%b required pc=%h instr=%h op=%b",
                             cyc, d0_pc, d0_instr, d0_op, exp_pc, w, w[15:11]); end
                exp_pc = exp_pc + 16'h1;
                pops++;
            end
            if (d0_req && m_gnt && !redirect) begin
                n_tests++; if (d0_addr !== exp_fetch) begin n_fail++;
                    $display("FAIL rnd_fetch_addr: cyc %0d got %h required %h", cyc, d0_addr, exp_fetch); end
                exp_fetch = exp_fetch + 16'h1;
            end
            redir_prev = redirect;
            rpc_prev   = redirect_pc;
            if (redirect) begin exp_pc = redirect_pc; exp_fetch = redirect_pc; end
        end
        @(posedge clk); #1 redirect = 0;
        n_tests++; if (pops < 40) begin n_fail++; $display("FAIL rnd_progress: got %0d pops required >= 40", pops); end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_backpressure();
        test_redirect_wait();
        test_redirect_pop_rvalid();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
